// File: rtl/seg_scan_mux.sv
// seg_scan_mux: double-buffered scanner for a common-anode multi-digit 7-segment display.
// Build macro LEADING_ZERO_BLANK_EN keeps the anodes of leading-zero digits off.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       value_in,
    input  logic                          load,
    input  logic                          enable,
    output logic [3:0]                    hex_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int DW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_LAST       = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIG_LAST       = DW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [CW-1:0]       slot_cnt_r, slot_cnt_s;
    logic [DW-1:0]       digit_r, digit_s;
    logic                boundary_s;
    logic [VW-1:0]       pending_r, pending_s;
    logic                pend_valid_r, pend_valid_s;
    logic [VW-1:0]       shadow_r, shadow_s;
    logic                enable_q_r;
    logic [3:0]          hex_r, hex_s;
    logic [NUM_DIGITS-1:0] an_r, an_s;
    logic                frame_done_r, frame_done_s;
    logic [NUM_DIGITS-1:0] vis_s;

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is visible when any nibble from k upward is non-zero; digit 0 always is.
    function automatic logic [NUM_DIGITS-1:0] visible_mask(input logic [VW-1:0] v);
        logic any_nz;
        any_nz = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            any_nz          = any_nz | (v[4*k +: 4] != 4'h0);
            visible_mask[k] = any_nz;
        end
        visible_mask[0] = 1'b1;
    endfunction
`endif

    // Slot counter, digit index and BLANK/DRIVE next-state.
    always_comb begin
        state_s    = state_r;
        slot_cnt_s = slot_cnt_r;
        digit_s    = digit_r;
        boundary_s = 1'b0;
        if (!enable) begin
            state_s    = ST_BLANK;
            slot_cnt_s = {CW{1'b0}};
            digit_s    = {DW{1'b0}};
        end else begin
            if (slot_cnt_r == CNT_LAST) begin
                slot_cnt_s = {CW{1'b0}};
            end else begin
                slot_cnt_s = slot_cnt_r + CW'(1);
            end
            case (state_r)
                ST_BLANK: begin
                    if (slot_cnt_r == CNT_BLANK_LAST) begin
                        state_s = ST_DRIVE;
                    end else begin
                        state_s = ST_BLANK;
                    end
                end
                ST_DRIVE: begin
                    if (slot_cnt_r == CNT_LAST) begin
                        state_s = ST_BLANK;
                        if (digit_r == DIG_LAST) begin
                            digit_s    = {DW{1'b0}};
                            boundary_s = 1'b1;
                        end else begin
                            digit_s = digit_r + DW'(1);
                        end
                    end else begin
                        state_s = ST_DRIVE;
                    end
                end
                default: state_s = ST_BLANK;
            endcase
        end
    end

    // Pending/shadow double buffer: shadow only moves at a frame wrap or on scan restart.
    always_comb begin
        pending_s    = load ? value_in : pending_r;
        pend_valid_s = load ? 1'b1 : pend_valid_r;
        shadow_s     = shadow_r;
        if (boundary_s) begin
            if (load) begin
                shadow_s = value_in;
            end else if (pend_valid_r) begin
                shadow_s = pending_r;
            end else begin
                shadow_s = shadow_r;
            end
            pend_valid_s = 1'b0;
        end else if (enable && !enable_q_r && pend_valid_r) begin
            shadow_s     = pending_r;
            pend_valid_s = load;
        end else begin
            shadow_s = shadow_r;
        end
    end

    // Output values for the coming cycle, so the registered outputs line up with the counters.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        vis_s = visible_mask(shadow_s);
`else
        vis_s = {NUM_DIGITS{1'b1}};
`endif
        hex_s = 4'h0;
        an_s  = {NUM_DIGITS{1'b1}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_s   = hex_s | ({4{digit_s == DW'(k)}} & shadow_s[4*k +: 4]);
            an_s[k] = ~((state_s == ST_DRIVE) && (digit_s == DW'(k)) && vis_s[k]);
        end
        frame_done_s = enable && (digit_s == DIG_LAST) && (slot_cnt_s == CNT_LAST);
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_BLANK;
            slot_cnt_r   <= {CW{1'b0}};
            digit_r      <= {DW{1'b0}};
            pending_r    <= {VW{1'b0}};
            pend_valid_r <= 1'b0;
            shadow_r     <= {VW{1'b0}};
            enable_q_r   <= 1'b0;
            hex_r        <= 4'h0;
            an_r         <= {NUM_DIGITS{1'b1}};
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            slot_cnt_r   <= slot_cnt_s;
            digit_r      <= digit_s;
            pending_r    <= pending_s;
            pend_valid_r <= pend_valid_s;
            shadow_r     <= shadow_s;
            enable_q_r   <= enable;
            hex_r        <= hex_s;
            an_r         <= an_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign hex_out    = hex_r;
    assign an         = an_r;
    assign digit_idx  = digit_r;
    assign frame_done = frame_done_r;

endmodule
